// File: rtl/bypass_regfile.sv
// Register file with same-cycle write bypass and a per-register scoreboard of
// in-flight writes that stalls decode on RAW hazards and counter overflow.
module bypass_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int RD_PORTS = 2,
  parameter int MAX_INFL = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [RD_PORTS-1:0]          rd_used,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         iss_valid,
  input  logic                         iss_wr,
  input  logic [ADDR_W-1:0]            iss_rd_addr,
  output logic                         stall,
  output logic                         sb_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = $clog2(MAX_INFL + 1);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [CNT_W-1:0]    cnt  [NUM_REGS];
  logic [RD_PORTS-1:0] raw_busy;
  logic                waw_full;
  logic                accept;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[p*ADDR_W +: ADDR_W];
    assign hit  = wr_en && (wr_addr == addr);
    assign rd_data[p*DATA_W +: DATA_W] = hit ? wr_data : regs[addr];
    // A retire landing this cycle satisfies one outstanding write, so it
    // only covers the hazard when exactly one write is pending.
    assign raw_busy[p] = rd_used[p] && (cnt[addr] > (hit ? CNT_W'(1) : CNT_W'(0)));
  end

  assign waw_full = iss_valid && iss_wr && (cnt[iss_rd_addr] == CNT_W'(MAX_INFL))
                    && !(wr_en && (wr_addr == iss_rd_addr));
  assign stall    = iss_valid && ((|raw_busy) || waw_full);
  assign accept   = iss_valid && iss_wr && !stall;
  assign inc_vec  = {{(NUM_REGS-1){1'b0}}, accept} << iss_rd_addr;
  assign dec_vec  = {{(NUM_REGS-1){1'b0}}, wr_en}  << wr_addr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the storage array is reset explicitly because reads after reset
  // must return zero; this prevents mapping it onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
        if (cnt[wr_addr] == '0) sb_err <= 1'b1;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + CNT_W'(1);
          2'b01:   if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bypass_regfile.sv
// Directed self-checking bench for bypass_regfile with hand-computed
// expectations; scoreboard counters are observed hierarchically.
module tb_bypass_regfile;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int RD_PORTS = 2;
  localparam int MAX_INFL = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS-1:0]        rd_used;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       iss_valid;
  logic                       iss_wr;
  logic [ADDR_W-1:0]          iss_rd_addr;
  logic                       stall;
  logic                       sb_err;

  int n_vec = 0;
  int n_err = 0;

  bypass_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS), .MAX_INFL(MAX_INFL)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_wr(iss_wr), .iss_rd_addr(iss_rd_addr), .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; checks run on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    rd_addr = '0; rd_used = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rd_addr = '0; rst = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [ADDR_W-1:0] a, input logic used);
    rd_addr[p*ADDR_W +: ADDR_W] = a;
    rd_used[p] = used;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd_addr = a;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  function automatic logic [DATA_W-1:0] port_data(input int p);
    return rd_data[p*DATA_W +: DATA_W];
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    tick();
    idle();
    settle();
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_sb_err", 32'(sb_err), 32'd0);
    check("reset_rd0", 32'(port_data(0)), 32'h0);

    // Write r3 (after issuing it so the scoreboard balances), read via bypass then storage.
    tick(); issue(4'd3);
    tick(); idle(); write(4'd3, 16'h1234); set_rd(0, 4'd3, 1'b0); set_rd(1, 4'd3, 1'b0);
    settle();
    check("bypass_r3_p0", 32'(port_data(0)), 32'h1234);
    check("bypass_r3_p1", 32'(port_data(1)), 32'h1234);
    tick(); idle(); set_rd(0, 4'd3, 1'b0); set_rd(1, 4'd4, 1'b0);
    settle();
    check("stored_r3", 32'(port_data(0)), 32'h1234);
    check("unwritten_r4", 32'(port_data(1)), 32'h0);
    check("balanced_sb_err", 32'(sb_err), 32'd0);

    // RAW hazard on r5, cleared by a same-cycle retire.
    tick(); idle(); issue(4'd5);
    tick(); idle(); iss_valid = 1'b1; set_rd(0, 4'd5, 1'b1);
    settle();
    check("raw_stall_r5", 32'(stall), 32'd1);
    rd_used = '0;
    #1;
    check("unused_port_no_stall", 32'(stall), 32'd0);
    iss_valid = 1'b0; set_rd(0, 4'd5, 1'b1);
    #1;
    check("no_valid_no_stall", 32'(stall), 32'd0);
    tick(); idle(); iss_valid = 1'b1; set_rd(0, 4'd5, 1'b1); write(4'd5, 16'hBEEF);
    settle();
    check("raw_cleared_by_retire", 32'(stall), 32'd0);
    check("raw_bypass_beef", 32'(port_data(0)), 32'hBEEF);
    tick(); idle();
    settle();
    check("cnt_r5_drained", 32'(dut.cnt[5]), 32'd0);

    // WAW-full on r2.
    for (int k = 0; k < MAX_INFL; k++) begin
      issue(4'd2);
      tick(); idle();
    end
    settle();
    check("cnt_r2_full", 32'(dut.cnt[2]), 32'd3);
    tick(); issue(4'd2);
    settle();
    check("waw_full_stall", 32'(stall), 32'd1);
    tick(); idle();
    settle();
    check("cnt_r2_held", 32'(dut.cnt[2]), 32'd3);
    tick(); issue(4'd2); write(4'd2, 16'h0002);
    settle();
    check("waw_retire_accepts", 32'(stall), 32'd0);
    tick(); idle();
    settle();
    check("cnt_r2_still_full", 32'(dut.cnt[2]), 32'd3);

    // Same-register and cross-register accept/retire.
    tick(); issue(4'd7);
    tick(); idle(); issue(4'd4);
    tick(); idle(); issue(4'd7); write(4'd7, 16'h0777);
    tick(); idle();
    settle();
    check("cnt_r7_same_edge", 32'(dut.cnt[7]), 32'd1);
    tick(); issue(4'd1); write(4'd4, 16'h0444);
    tick(); idle();
    settle();
    check("cnt_r1_inc", 32'(dut.cnt[1]), 32'd1);
    check("cnt_r4_dec", 32'(dut.cnt[4]), 32'd0);

    // Duplicate read addresses; a single pending write covered by a retire.
    tick(); iss_valid = 1'b1; set_rd(0, 4'd7, 1'b0); set_rd(1, 4'd7, 1'b1);
    settle();
    check("dup_addr_p1_busy", 32'(stall), 32'd1);
    write(4'd7, 16'h0707);
    #1;
    check("dup_addr_retire_covers", 32'(stall), 32'd0);
    tick(); idle();
    settle();
    check("no_underflow_yet", 32'(sb_err), 32'd0);

    // Underflow on r9.
    tick(); write(4'd9, 16'h55AA);
    tick(); idle(); set_rd(0, 4'd9, 1'b0);
    settle();
    check("underflow_data_r9", 32'(port_data(0)), 32'h55AA);
    check("underflow_cnt_r9", 32'(dut.cnt[9]), 32'd0);
    check("underflow_sb_err", 32'(sb_err), 32'd1);
    tick(); tick();
    settle();
    check("sb_err_sticky", 32'(sb_err), 32'd1);

    // Reset with simultaneous write and issue; stall uses pre-reset counters.
    tick(); rst = 1'b1; write(4'd6, 16'h6666); issue(4'd8); set_rd(0, 4'd2, 1'b1);
    settle();
    check("stall_during_reset", 32'(stall), 32'd1);
    tick(); idle();
    settle();
    check("post_reset_sb_err", 32'(sb_err), 32'd0);
    for (int r = 0; r < 2 ** ADDR_W; r++) begin
      iss_valid = 1'b1;
      set_rd(0, ADDR_W'(r), 1'b1);
      set_rd(1, ADDR_W'(r), 1'b1);
      #1;
      check($sformatf("post_reset_data_r%0d", r), 32'(port_data(0)), 32'h0);
      check($sformatf("post_reset_stall_r%0d", r), 32'(stall), 32'd0);
    end
    tick(); idle(); issue(4'd8);
    settle();
    check("post_reset_issue_ok", 32'(stall), 32'd0);
    tick(); idle();
    settle();
    check("post_reset_cnt_r8", 32'(dut.cnt[8]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bypass_regfile.md
BYPASS_REGFILE -- requirements
Module: bypass_regfile

Interface
REQ-001 Parameter DATA_W, default 16: register data width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter RD_PORTS, default 2: number of read ports.
REQ-004 Parameter MAX_INFL, default 3: max in-flight writes per register; counter width = clog2(MAX_INFL+1).
REQ-005 One clock, clk; reset is rst, synchronous, active-high; all state updates on the rising edge of clk.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rd_addr  in  RD_PORTS*ADDR_W  read addresses; port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 rd_used  in  RD_PORTS  port p operand is needed by the instruction in decode.
REQ-010 rd_data  out  RD_PORTS*DATA_W  read data, packed as rd_addr.
REQ-011 wr_en  in  1  writeback strobe.
REQ-012 wr_addr  in  ADDR_W  writeback destination.
REQ-013 wr_data  in  DATA_W  writeback value.
REQ-014 iss_valid  in  1  decode stage presents an instruction.
REQ-015 iss_wr  in  1  that instruction writes a register.
REQ-016 iss_rd_addr  in  ADDR_W  its destination register.
REQ-017 stall  out  1  decode must hold; the issue is not accepted.
REQ-018 sb_err  out  1  sticky scoreboard-underflow flag.

Function
REQ-019 Storage: NUM_REGS x DATA_W registers.
REQ-020 A write to reg[wr_addr] occurs at the clock edge when wr_en=1; it is visible in storage from the next cycle.
REQ-021 rd_data[p] is combinational: wr_data when wr_en=1 and wr_addr==rd_addr[p] (same-cycle bypass), else reg[rd_addr[p]].
REQ-022 Each register has a pending counter cnt[r] holding 0..MAX_INFL.
REQ-023 Issue is accepted when iss_valid=1, iss_wr=1 and stall=0.
REQ-024 Retire occurs when wr_en=1.
REQ-025 Counter update per edge: accept only -> cnt+1; retire only -> cnt-1; accept and retire on the same register -> unchanged; accept and retire on different registers -> each updates independently.
REQ-026 Retire with cnt[wr_addr]==0: the data write still occurs, the counter stays 0, and sb_err is set to 1 until reset.
REQ-027 RAW busy for port p: rd_used[p]=1 and cnt[rd_addr[p]] > b, where b=1 if wr_en=1 and wr_addr==rd_addr[p], else b=0.
REQ-028 WAW-full: iss_valid=1, iss_wr=1 and cnt[iss_rd_addr]==MAX_INFL, with no retire to iss_rd_addr this cycle.
REQ-029 stall is combinational and equals iss_valid AND (any port RAW busy OR WAW-full); stall=0 when iss_valid=0.
REQ-030 rd_used=0 ports never contribute to stall, regardless of counter value.
REQ-031 Duplicate rd_addr values across ports are legal; each port evaluates independently.
REQ-032 Counters never wrap; an accepted issue can never push any counter above MAX_INFL, because REQ-028 stalls it.

Reset
REQ-033 While rst=1 at an edge: all registers are set to 0, all cnt are set to 0, and sb_err is set to 0; wr_en and issue on that edge are ignored.
REQ-034 During reset, rd_data still follows REQ-021 combinationally, and stall follows REQ-029 using the current (pre-reset) counters.
REQ-035 Reset asserted mid-operation discards all pending state; the first cycle after reset shows cnt=0 and reg=0 for every register.

Verification
REQ-036 Reset, then write r3=0x1234 -> the next cycle rd_addr[0]=3 gives 0x1234; in the write cycle itself, rd_data shows 0x1234 via bypass.
REQ-037 Issue a write to r5; next cycle rd_used[0]=1, rd_addr[0]=5, no wr_en -> stall=1; then wr_en to r5 with wr_data=0xBEEF -> stall=0 and rd_data[0]=0xBEEF in that same cycle.
REQ-038 Issue to r2 three times (MAX_INFL=3), then a fourth issue to r2 -> stall=1, cnt[r2] stays 3; fourth issue with a same-cycle retire to r2 -> accepted, cnt stays 3.
REQ-039 Same-edge accept to r7 and retire to r7 with cnt[r7]=1 -> cnt[r7] stays 1; accept to r1 and retire to r4 -> cnt[r1]+1 and cnt[r4]-1.
REQ-040 wr_en to r9 with cnt[r9]=0 -> reg[r9] updated, cnt[r9]=0, sb_err=1 and held; rst=1 for one edge -> sb_err=0, all registers read 0.
REQ-041 Load counters and registers, assert rst for one cycle with a simultaneous wr_en and issue -> afterwards all cnt=0, all registers 0, stall=0 for any rd_used pattern.
